// File: rtl/multi_voice_wave.sv
`default_nettype none
// ============================================================================
// Module      : multi_voice_wave
// Description : Time-multiplexed N-voice waveform generator. One shared voice
//               datapath is stepped once per voice after each sample_tick.
//               Each voice combines saw, triangle, pulse and noise
//               waveforms, with chained hard sync and ring modulation. The
//               voice contributions are summed, and the sum is saturated
//               into one signed mix sample per frame.
// Ports       : main_clk    - single clock, rising edge
//               reset       - synchronous, active-low
//               sample_tick - one-cycle frame strobe
//               cfg_we      - config write enable
//               cfg_voice   - voice index of the config write
//               cfg_addr    - 0 freq, 1 pulse_width, 2 control, 3 reserved
//               cfg_wdata   - config write data, LSB-aligned
//               mix_out     - signed saturated mix sample
//               mix_valid   - one-cycle pulse marking a new mix_out
//               busy        - frame in progress
//               overrun     - sticky; a tick arrived while busy
//               voice_msb   - accumulator MSB of each voice
// Revision    : 1.0 - initial release
// ============================================================================
module multi_voice_wave #(
    parameter int NUM_VOICES       = 3,
    parameter int FREQ_BITS        = 16,
    parameter int PULSEWIDTH_BITS  = 12,
    parameter int OUTPUT_BITS      = 12,
    parameter int ACCUMULATOR_BITS = 24,
    parameter int MIX_BITS         = 14
) (
    input  logic                          main_clk,
    input  logic                          reset,
    input  logic                          sample_tick,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [1:0]                    cfg_addr,
    input  logic [15:0]                   cfg_wdata,
    output logic signed [MIX_BITS-1:0]    mix_out,
    output logic                          mix_valid,
    output logic                          busy,
    output logic                          overrun,
    output logic [NUM_VOICES-1:0]         voice_msb
);

    localparam int c_VB = $clog2(NUM_VOICES);
    localparam int c_AW = ACCUMULATOR_BITS;
    localparam int c_OB = OUTPUT_BITS;
    localparam int c_SW = OUTPUT_BITS + c_VB + 1;

    localparam logic [22:0]     c_LFSR_SEED  = 23'h7FFFF8;
    localparam logic [c_VB-1:0] c_LAST_VOICE = c_VB'(NUM_VOICES - 1);
    localparam logic [c_VB:0]   c_NUM_VOICES = (c_VB + 1)'(NUM_VOICES);
    localparam logic [c_OB-1:0] c_SIGN_FLIP  = {1'b1, {(c_OB - 1){1'b0}}};

    localparam logic signed [31:0] c_MIX_MAX = (32'sd1 <<< (MIX_BITS - 1)) - 32'sd1;
    localparam logic signed [31:0] c_MIX_MIN = -(32'sd1 <<< (MIX_BITS - 1));

    // Control register bit positions
    localparam int c_CB_GATE  = 0;
    localparam int c_CB_SYNC  = 1;
    localparam int c_CB_RING  = 2;
    localparam int c_CB_TRI   = 3;
    localparam int c_CB_PULSE = 4;
    localparam int c_CB_SAW   = 5;
    localparam int c_CB_NOISE = 6;
    localparam int c_CB_TEST  = 7;

    // FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_STEP = 2'd1;
    localparam logic [1:0] c_ST_MIX  = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [FREQ_BITS-1:0]       r_freq  [NUM_VOICES];
    logic [PULSEWIDTH_BITS-1:0] r_pw    [NUM_VOICES];
    logic [7:0]                 r_ctrl  [NUM_VOICES];
    logic [c_AW-1:0]            r_acc   [NUM_VOICES];
    logic [22:0]                r_lfsr  [NUM_VOICES];
    logic [NUM_VOICES-1:0]      r_msb_rose;
    logic signed [c_SW-1:0]     r_mix_acc;

    logic [1:0]      r_state;
    logic [c_VB-1:0] r_vidx;

    // FSM decode
    logic [1:0]      w_state_next;
    logic [c_VB-1:0] w_vidx_next;
    logic            w_frame_start;
    logic            w_step;
    logic            w_mix;

    // Voice datapath
    logic [c_VB-1:0]            w_src;
    logic [7:0]                 w_ctrl;
    logic [c_AW-1:0]            w_acc_old;
    logic [c_AW-1:0]            w_acc_new;
    logic [22:0]                w_lfsr_new;
    logic                       w_msb_rose_new;
    logic                       w_bit19_rose;
    logic                       w_fold;
    logic [c_OB-1:0]            w_saw;
    logic [c_OB-1:0]            w_tri;
    logic [c_OB-1:0]            w_pulse;
    logic [c_OB-1:0]            w_noise;
    logic [c_OB-1:0]            w_value;
    logic                       w_any_wave;
    logic [c_OB-1:0]            w_signed;
    logic signed [c_SW-1:0]     w_contrib;

    // Mix saturation
    logic signed [31:0]         w_sum_wide;
    logic signed [MIX_BITS-1:0] w_clamped;

    logic w_cfg_ok;
    logic w_unused;

    assign w_unused = &{1'b0, cfg_wdata};

    // ------------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge main_clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_vidx  <= '0;
        end else begin
            r_state <= w_state_next;
            r_vidx  <= w_vidx_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_vidx_next   = r_vidx;
        w_frame_start = 1'b0;
        w_step        = 1'b0;
        w_mix         = 1'b0;
        busy          = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (sample_tick) begin
                    w_state_next  = c_ST_STEP;
                    w_vidx_next   = '0;
                    w_frame_start = 1'b1;
                end
            end
            c_ST_STEP: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_vidx == c_LAST_VOICE) begin
                    w_state_next = c_ST_MIX;
                    w_vidx_next  = '0;
                end else begin
                    w_vidx_next = r_vidx + c_VB'(1);
                end
            end
            c_ST_MIX: begin
                busy         = 1'b1;
                w_mix        = 1'b1;
                w_state_next = c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
                w_vidx_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shared voice datapath, evaluated for voice r_vidx
    // ------------------------------------------------------------------------
    always_comb begin
        // Modulation source is the previous voice; voice 0 wraps to the last
        // voice, whose state is still from the previous frame at this point.
        w_src     = (r_vidx == '0) ? c_LAST_VOICE : r_vidx - c_VB'(1);
        w_ctrl    = r_ctrl[r_vidx];
        w_acc_old = r_acc[r_vidx];

        if (w_ctrl[c_CB_TEST]) begin
            w_acc_new = '0;
        end else if (w_ctrl[c_CB_SYNC] && r_msb_rose[w_src]) begin
            w_acc_new = '0;
        end else begin
            w_acc_new = w_acc_old + c_AW'(r_freq[r_vidx]);
        end

        w_msb_rose_new = !w_acc_old[c_AW-1] && w_acc_new[c_AW-1];
        w_bit19_rose   = !w_acc_old[19] && w_acc_new[19];

        if (w_ctrl[c_CB_TEST]) begin
            w_lfsr_new = c_LFSR_SEED;
        end else if (w_bit19_rose) begin
            w_lfsr_new = {r_lfsr[r_vidx][21:0], r_lfsr[r_vidx][22] ^ r_lfsr[r_vidx][17]};
        end else begin
            w_lfsr_new = r_lfsr[r_vidx];
        end

        w_saw   = w_acc_new[c_AW-1 -: c_OB];
        // Ring modulation swaps the fold source from a square to the XOR of
        // this voice's MSB with the source voice's current MSB.
        w_fold  = w_acc_new[c_AW-1] ^ (w_ctrl[c_CB_RING] & r_acc[w_src][c_AW-1]);
        w_tri   = w_fold ? ~w_acc_new[c_AW-2 -: c_OB] : w_acc_new[c_AW-2 -: c_OB];
        w_pulse = (w_acc_new[c_AW-1 -: PULSEWIDTH_BITS] >= r_pw[r_vidx]) ? '1 : '0;
        w_noise = w_lfsr_new[22 -: c_OB];

        w_value    = '1;
        w_any_wave = 1'b0;
        if (w_ctrl[c_CB_TRI]) begin
            w_value    = w_value & w_tri;
            w_any_wave = 1'b1;
        end
        if (w_ctrl[c_CB_PULSE]) begin
            w_value    = w_value & w_pulse;
            w_any_wave = 1'b1;
        end
        if (w_ctrl[c_CB_SAW]) begin
            w_value    = w_value & w_saw;
            w_any_wave = 1'b1;
        end
        if (w_ctrl[c_CB_NOISE]) begin
            w_value    = w_value & w_noise;
            w_any_wave = 1'b1;
        end
        if (!w_any_wave) begin
            w_value = '0;
        end

        // Offset-binary to two's complement by flipping the top bit
        w_signed = w_value ^ c_SIGN_FLIP;
        if (w_ctrl[c_CB_GATE]) begin
            w_contrib = {{(c_VB + 1){w_signed[c_OB-1]}}, w_signed};
        end else begin
            w_contrib = '0;
        end
    end

    // Saturate the frame sum into the mix output range
    always_comb begin
        w_sum_wide = 32'(r_mix_acc);
        if (w_sum_wide > c_MIX_MAX) begin
            w_clamped = c_MIX_MAX[MIX_BITS-1:0];
        end else if (w_sum_wide < c_MIX_MIN) begin
            w_clamped = c_MIX_MIN[MIX_BITS-1:0];
        end else begin
            w_clamped = w_sum_wide[MIX_BITS-1:0];
        end
    end

    assign w_cfg_ok = cfg_we && (cfg_addr != 2'd3) && ({1'b0, cfg_voice} < c_NUM_VOICES);

    // ------------------------------------------------------------------------
    // Config register file, voice state and mix registers
    // ------------------------------------------------------------------------
    always_ff @(posedge main_clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_freq[i] <= '0;
                r_pw[i]   <= '0;
                r_ctrl[i] <= '0;
                r_acc[i]  <= '0;
                r_lfsr[i] <= c_LFSR_SEED;
            end
            r_msb_rose <= '0;
            r_mix_acc  <= '0;
            mix_out    <= '0;
            mix_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Config writes land at the clock edge, so a voice stepped in the
            // same cycle still sees its previous settings.
            if (w_cfg_ok) begin
                case (cfg_addr)
                    2'd0:    r_freq[cfg_voice] <= cfg_wdata[FREQ_BITS-1:0];
                    2'd1:    r_pw[cfg_voice]   <= cfg_wdata[PULSEWIDTH_BITS-1:0];
                    default: r_ctrl[cfg_voice] <= cfg_wdata[7:0];
                endcase
            end

            if (w_frame_start) begin
                r_mix_acc <= '0;
            end

            if (w_step) begin
                r_acc[r_vidx]      <= w_acc_new;
                r_lfsr[r_vidx]     <= w_lfsr_new;
                r_msb_rose[r_vidx] <= w_msb_rose_new;
                r_mix_acc          <= r_mix_acc + w_contrib;
            end

            mix_valid <= w_mix;
            if (w_mix) begin
                mix_out <= w_clamped;
            end

            if (sample_tick && busy) begin
                overrun <= 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice_msb
            assign voice_msb[g] = r_acc[g][c_AW-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_multi_voice_wave.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_voice_wave
// Description : Directed self-checking bench for multi_voice_wave. A default
//               instance (MIX_BITS=14) and a MIX_BITS=12 instance share all
//               stimulus so that saturation can be observed on the narrow one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_voice_wave;

    localparam int c_NV = 3;

    logic        clk;
    logic        rst_n;
    logic        sample_tick;
    logic        cfg_we;
    logic [1:0]  cfg_voice;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;

    logic signed [13:0] mix_a;
    logic               valid_a;
    logic               busy_a;
    logic               ovr_a;
    logic [2:0]         msb_a;

    logic signed [11:0] mix_b;
    logic               valid_b;
    logic               busy_b;
    logic               ovr_b;
    logic [2:0]         msb_b;

    int checks;
    int failures;

    multi_voice_wave dut_a (
        .main_clk    (clk),
        .reset       (rst_n),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .mix_out     (mix_a),
        .mix_valid   (valid_a),
        .busy        (busy_a),
        .overrun     (ovr_a),
        .voice_msb   (msb_a)
    );

    multi_voice_wave #(.MIX_BITS(12)) dut_b (
        .main_clk    (clk),
        .reset       (rst_n),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .mix_out     (mix_b),
        .mix_valid   (valid_b),
        .busy        (busy_b),
        .overrun     (ovr_b),
        .voice_msb   (msb_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] v, input logic [1:0] a,
                             input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_voice = v;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
    endtask

    // Returns in cycle N+2 of the frame, where mix_valid is high
    task automatic run_frame();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        repeat (c_NV + 1) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic saw_valid;
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        sample_tick = 1'b0;
        cfg_we      = 1'b0;
        cfg_voice   = '0;
        cfg_addr    = '0;
        cfg_wdata   = '0;
        repeat (3) step();

        // Reset state
        check("rst_mix", mix_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_overrun", ovr_a, 0);
        check("rst_voice_msb", msb_a, 0);
        rst_n = 1'b1;
        step();

        // Dropped writes: reserved address and out-of-range voice
        cfg_write(2'd3, 2'd2, 16'h0021);
        cfg_write(2'd0, 2'd3, 16'hFFFF);
        run_frame();
        check("drop_valid", valid_a, 1);
        check("drop_mix", mix_a, 0);

        // Single saw voice, frame timing
        cfg_write(2'd0, 2'd0, 16'h1000);
        cfg_write(2'd0, 2'd2, 16'h0021);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        for (int c = 1; c <= c_NV + 1; c++) begin
            check("t1_busy", busy_a, 1);
            check("t1_valid_early", valid_a, 0);
            step();
        end
        check("t1_valid", valid_a, 1);
        check("t1_busy_done", busy_a, 0);
        check("t1_mix", mix_a, -2047);
        check("t1_mix_narrow", mix_b, -2047);
        step();
        check("t1_valid_pulse", valid_a, 0);

        // Pulse on voice 0, synced saw on voice 1
        do_reset();
        cfg_write(2'd0, 2'd0, 16'h8000);
        cfg_write(2'd0, 2'd1, 16'h0800);
        cfg_write(2'd0, 2'd2, 16'h0011);
        cfg_write(2'd1, 2'd0, 16'h1000);
        cfg_write(2'd1, 2'd2, 16'h0023);
        run_frame();
        check("t2_tick1", mix_a, -4095);
        check("t2_tick1_narrow", mix_b, -2048);
        repeat (254) run_frame();
        check("t2_tick255", mix_a, -3841);
        check("t2_msb255", msb_a, 0);
        run_frame();
        check("t2_tick256", mix_a, -1);
        check("t2_msb256", msb_a, 1);
        run_frame();
        check("t2_tick257", mix_a, 0);

        // Test bit holds the accumulator and reseeds the LFSR
        do_reset();
        cfg_write(2'd2, 2'd0, 16'h1000);
        cfg_write(2'd2, 2'd2, 16'h00C1);
        for (int t = 0; t < 3; t++) begin
            run_frame();
            check("t4_noise_seed", mix_a, 2047);
            check("t4_acc_held", msb_a, 0);
        end
        cfg_write(2'd2, 2'd2, 16'h0021);
        run_frame();
        check("t4_resume", mix_a, -2047);

        // Overrun: tick during a frame is ignored and sticky
        check("t5_ovr_clear", ovr_a, 0);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("t5_ovr_set", ovr_a, 1);
        step();
        step();
        check("t5_valid", valid_a, 1);
        check("t5_mix", mix_a, -2046);
        step();
        check("t5_ovr_sticky", ovr_a, 1);
        check("t5_tick_ignored", busy_a, 0);

        // Reset mid-frame aborts the frame
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        rst_n       = 1'b0;
        step();
        rst_n = 1'b1;
        check("t5_abort_valid", valid_a, 0);
        check("t5_abort_busy", busy_a, 0);
        check("t5_abort_ovr", ovr_a, 0);
        check("t5_abort_mix", mix_a, 0);
        check("t5_abort_msb", msb_a, 0);
        saw_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            saw_valid = saw_valid | valid_a;
            step();
        end
        check("t5_no_valid", saw_valid, 0);

        // Saturation on the narrow mix
        do_reset();
        for (int v = 0; v < c_NV; v++) begin
            cfg_write(2'(v), 2'd2, 16'h0021);
        end
        run_frame();
        check("t6_neg_wide", mix_a, -6144);
        check("t6_neg_narrow", mix_b, -2048);
        for (int v = 0; v < c_NV; v++) begin
            cfg_write(2'(v), 2'd0, 16'hFFFF);
        end
        repeat (256) run_frame();
        check("t6_pos_wide", mix_a, 6141);
        check("t6_pos_narrow", mix_b, 2047);
        check("t6_msb", msb_a, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
